// File: rtl/xor_stream_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : xor_stream_descrambler
// Purpose  : Receive-side additive descrambler. Each accepted byte is XORed
//            with the low byte of a 16-bit Fibonacci LFSR keystream. The LFSR
//            advances 8 steps per accepted byte and reloads the stored seed
//            at every frame boundary. The result goes out through a
//            one-stage output register with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   FRAME_LEN    : bytes per frame before the seed is reloaded (0 = never).
//                  Valid range is 0..256.
//   DEFAULT_SEED : seed applied at reset and substituted for a zero seed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   seed_valid, seed    : load a new LFSR seed (takes priority over data)
//   in_valid, in_data   : scrambled byte input
//   in_ready            : byte is accepted this cycle
//   out_valid, out_data : descrambled byte output (registered)
//   out_ready           : sink accepts out_data
//   synced              : a seed has been loaded (RUN state)
//   byte_cnt            : bytes accepted in the current frame
// Optional build macro DESCRAMBLER_PARITY_EN adds:
//   in_parity           : even parity over the scrambled in_data
//   parity_err          : sticky error flag, cleared by rst or a seed load
// ============================================================================
module xor_stream_descrambler #(
    parameter int          FRAME_LEN    = 16,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [15:0] seed,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        synced,
    output logic [7:0]  byte_cnt
`ifdef DESCRAMBLER_PARITY_EN
    ,
    input  logic        in_parity,
    output logic        parity_err
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Nine bits so that FRAME_LEN = 256 can match a counter of 255 plus one.
    localparam logic [8:0] FRAME_LEN_C = FRAME_LEN[8:0];
    localparam bit         AUTO_RELOAD = (FRAME_LEN != 0);

    // Eight Fibonacci steps unrolled into one combinational stage.
    function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        end
        return t;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] stored_seed_q, stored_seed_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        synced_q, synced_d;
`ifdef DESCRAMBLER_PARITY_EN
    logic        parity_err_q, parity_err_d;
`endif

    logic [15:0] seed_eff;
    logic [15:0] lfsr_adv;
    logic [8:0]  cnt_inc;
    logic        frame_end;
    logic        in_ready_w;
    logic        accept;

    always_comb begin
        seed_eff   = (seed == 16'h0000) ? DEFAULT_SEED : seed;
        lfsr_adv   = lfsr_step8(lfsr_q);
        cnt_inc    = {1'b0, byte_cnt_q} + 9'd1;
        frame_end  = AUTO_RELOAD && (cnt_inc == FRAME_LEN_C);
        // A seed load in the same cycle blocks the byte so that it is never
        // descrambled with a key from the seed being replaced.
        in_ready_w = synced_q && !seed_valid && (!out_valid_q || out_ready);
        accept     = (state_q == ST_RUN) && in_valid && in_ready_w;

        state_d       = state_q;
        lfsr_d        = lfsr_q;
        stored_seed_d = stored_seed_q;
        byte_cnt_d    = byte_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        synced_d      = synced_q;
`ifdef DESCRAMBLER_PARITY_EN
        parity_err_d  = parity_err_q;
`endif

        if (seed_valid) begin
            state_d       = ST_RUN;
            lfsr_d        = seed_eff;
            stored_seed_d = seed_eff;
            byte_cnt_d    = 8'd0;
            synced_d      = 1'b1;
`ifdef DESCRAMBLER_PARITY_EN
            parity_err_d  = 1'b0;
`endif
        end else if (accept) begin
            // Frame boundary: restart the keystream from the stored seed.
            lfsr_d     = frame_end ? stored_seed_q : lfsr_adv;
            byte_cnt_d = frame_end ? 8'd0 : cnt_inc[7:0];
`ifdef DESCRAMBLER_PARITY_EN
            if ((^in_data) != in_parity) begin
                parity_err_d = 1'b1;
            end
`endif
        end

        // Output stage: a new accept refills the register even while it is
        // being drained, which keeps throughput at one byte per cycle.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ lfsr_q[7:0];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= DEFAULT_SEED;
            stored_seed_q <= DEFAULT_SEED;
            byte_cnt_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            synced_q      <= 1'b0;
`ifdef DESCRAMBLER_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            stored_seed_q <= stored_seed_d;
            byte_cnt_q    <= byte_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            synced_q      <= synced_d;
`ifdef DESCRAMBLER_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign synced    = synced_q;
    assign byte_cnt  = byte_cnt_q;
`ifdef DESCRAMBLER_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_stream_descrambler
// Purpose  : Self-checking bench for xor_stream_descrambler. Table-driven
//            vectors, hand-written multi-cycle sequences, and a randomized
//            run compared against a bit-stream keystream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_stream_descrambler;

    localparam int          FRAME_LEN    = 4;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic [15:0] seed;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        synced;
    logic [7:0]  byte_cnt;
`ifdef DESCRAMBLER_PARITY_EN
    logic        in_parity;
    logic        parity_err;
    logic        par_flip = 1'b0;
    assign in_parity = (^in_data) ^ par_flip;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xor_stream_descrambler #(
        .FRAME_LEN   (FRAME_LEN),
        .DEFAULT_SEED(DEFAULT_SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_valid(seed_valid),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .synced    (synced),
        .byte_cnt  (byte_cnt)
`ifdef DESCRAMBLER_PARITY_EN
        ,
        .in_parity (in_parity),
        .parity_err(parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Keystream model: the LFSR viewed as a bit sequence x[n] where the
    // register holds x[t..t+15] (x[t] in the MSB) and each new bit obeys
    // x[n] = x[n-16]^x[n-14]^x[n-13]^x[n-11]. Byte k of a frame is the
    // register's low byte after 8*k steps.
    function automatic logic [7:0] key_of(input logic [15:0] s0, input int k);
        bit          x[];
        logic [7:0]  key;
        x = new[8 * k + 16];
        for (int i = 0; i < 16; i++) x[i] = s0[15 - i];
        for (int n = 16; n < 8 * k + 16; n++) x[n] = x[n-16] ^ x[n-14] ^ x[n-13] ^ x[n-11];
        for (int j = 0; j < 8; j++) key[j] = x[8 * k + 15 - j];
        return key;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_valid = 1'b1;
        seed       = s;
        cyc();
        seed_valid = 1'b0;
    endtask

    typedef struct {
        bit          reseed;
        logic [15:0] seed;
        logic [7:0]  din;
        logic [7:0]  exp_out;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vt[10];

    // Random-phase model state
    bit          m_synced;
    logic [15:0] m_seed;
    int          m_k;
    bit          m_ov;
    logic [7:0]  m_od;
    bit          m_perr;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  k0, k1;
        logic [15:0] s_eff;
        bit          exp_ready, acc;
        logic [7:0]  nod;

        // Stimulus table: seed 1 stream, frame wrap at 4, zero-seed fallback.
        vt[0] = '{1'b1, 16'h0001, 8'h01, 8'h00,                        8'd1};
        vt[1] = '{1'b0, 16'h0000, 8'h55, 8'h55,                        8'd2};
        vt[2] = '{1'b0, 16'h0000, 8'h0D, 8'h0D ^ key_of(16'h0001, 2),  8'd3};
        vt[3] = '{1'b1, 16'h0001, 8'h00, 8'h01,                        8'd1};
        vt[4] = '{1'b0, 16'h0000, 8'h00, 8'h00,                        8'd2};
        vt[5] = '{1'b0, 16'h0000, 8'h00, key_of(16'h0001, 2),          8'd3};
        vt[6] = '{1'b0, 16'h0000, 8'h00, key_of(16'h0001, 3),          8'd0};
        vt[7] = '{1'b0, 16'h0000, 8'h00, 8'h01,                        8'd1};
        vt[8] = '{1'b1, 16'h0000, 8'hE1, 8'h00,                        8'd1};
        vt[9] = '{1'b0, 16'h0000, 8'h00, key_of(DEFAULT_SEED, 1),      8'd2};

        rst        = 1'b1;
        seed_valid = 1'b0;
        seed       = 16'h0000;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Unsynced: data offered but never accepted.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        cyc();
        cyc();
        cyc();
        check("idle in_ready", in_ready, 0);
        check("idle out_valid", out_valid, 0);
        check("idle out_data", out_data, 8'h00);
        check("idle synced", synced, 0);
        check("idle byte_cnt", byte_cnt, 0);
`ifdef DESCRAMBLER_PARITY_EN
        check("idle parity_err", parity_err, 0);
`endif
        in_valid = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            if (vt[i].reseed) begin
                load_seed(vt[i].seed);
                check($sformatf("tbl[%0d] synced", i), synced, 1);
                check($sformatf("tbl[%0d] cnt after seed", i), byte_cnt, 0);
            end
            in_valid  = 1'b1;
            in_data   = vt[i].din;
            out_ready = 1'b1;
            #1;
            check($sformatf("tbl[%0d] in_ready", i), in_ready, 1);
            cyc();
            in_valid = 1'b0;
            check($sformatf("tbl[%0d] out_valid", i), out_valid, 1);
            check($sformatf("tbl[%0d] out_data", i), out_data, vt[i].exp_out);
            check($sformatf("tbl[%0d] byte_cnt", i), byte_cnt, vt[i].exp_cnt);
        end
        cyc();
        check("drain out_valid", out_valid, 0);

        // Backpressure: one byte held for 3 cycles, the next waits.
        load_seed(16'h1234);
        k0 = key_of(16'h1234, 0);
        k1 = key_of(16'h1234, 1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        cyc();
        out_ready = 1'b0;
        in_data   = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp in_ready", in_ready, 0);
            cyc();
            check("bp out_valid", out_valid, 1);
            check("bp out_data held", out_data, 8'hA5 ^ k0);
            check("bp byte_cnt", byte_cnt, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        check("bp next out_data", out_data, 8'h3C ^ k1);
        check("bp next byte_cnt", byte_cnt, 2);
        check("bp next out_valid", out_valid, 1);
        cyc();
        check("bp no dup out_valid", out_valid, 0);

        // Seed load colliding with a byte mid-stream
        in_valid = 1'b1;
        in_data  = 8'h77;
`ifdef DESCRAMBLER_PARITY_EN
        par_flip = 1'b1;
`endif
        cyc();
`ifdef DESCRAMBLER_PARITY_EN
        par_flip = 1'b0;
        check("parity_err set", parity_err, 1);
`endif
        check("pre-collide out_data", out_data, 8'h77 ^ key_of(16'h1234, 2));
        check("pre-collide byte_cnt", byte_cnt, 3);
        seed_valid = 1'b1;
        seed       = 16'h0BEE;
        in_data    = 8'h11;
        #1;
        check("collide in_ready", in_ready, 0);
        cyc();
        seed_valid = 1'b0;
        check("collide byte_cnt", byte_cnt, 0);
        check("collide out_valid", out_valid, 0);
`ifdef DESCRAMBLER_PARITY_EN
        check("parity_err cleared", parity_err, 0);
`endif
        cyc();
        in_valid = 1'b0;
        check("post-collide out_data", out_data, 8'h11 ^ key_of(16'h0BEE, 0));
        check("post-collide byte_cnt", byte_cnt, 1);

        // Reset while a byte is held drops it.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        cyc();
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 8'h00);
        check("rst synced", synced, 0);
        check("rst byte_cnt", byte_cnt, 0);

        // Randomized run against the keystream model
        m_synced = 1'b0;
        m_seed   = DEFAULT_SEED;
        m_k      = 0;
        m_ov     = 1'b0;
        m_od     = 8'h00;
        m_perr   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            seed_valid = ($urandom_range(0, 19) == 0);
            seed       = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 8'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
`ifdef DESCRAMBLER_PARITY_EN
            par_flip   = ($urandom_range(0, 7) == 0);
`endif
            #1;
            exp_ready = m_synced && !seed_valid && (!m_ov || out_ready);
            check("rnd in_ready", in_ready, exp_ready);

            if (rst) begin
                m_synced = 1'b0;
                m_seed   = DEFAULT_SEED;
                m_k      = 0;
                m_ov     = 1'b0;
                m_od     = 8'h00;
                m_perr   = 1'b0;
            end else begin
                acc = exp_ready && in_valid;
                nod = 8'h00;
                if (acc) begin
                    nod = in_data ^ key_of(m_seed, m_k);
                    m_k++;
                    if (FRAME_LEN != 0 && m_k == FRAME_LEN) m_k = 0;
                    m_k = m_k % 256;
`ifdef DESCRAMBLER_PARITY_EN
                    if (par_flip) m_perr = 1'b1;
`endif
                end
                if (seed_valid) begin
                    s_eff    = (seed == 16'h0000) ? DEFAULT_SEED : seed;
                    m_seed   = s_eff;
                    m_k      = 0;
                    m_synced = 1'b1;
                    m_perr   = 1'b0;
                end
                if (acc) begin
                    m_ov = 1'b1;
                    m_od = nod;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end

            cyc();
            check("rnd out_valid", out_valid, m_ov);
            check("rnd out_data", out_data, m_od);
            check("rnd byte_cnt", byte_cnt, m_k);
            check("rnd synced", synced, m_synced);
`ifdef DESCRAMBLER_PARITY_EN
            check("rnd parity_err", parity_err, m_perr);
`endif
        end

        rst        = 1'b0;
        seed_valid = 1'b0;
        in_valid   = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
